slot_tick_sched: RTL and testbench



---
 rtl/slot_tick_sched_pkg.sv | 23 ++
 rtl/slot_tick_sched_if.sv | 23 ++
 rtl/slot_tick_sched_pow2_tick.sv | 17 +
 rtl/slot_tick_sched.sv | 123 ++++++++++++
 tb/tb_slot_tick_sched.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/slot_tick_sched_pkg.sv
// Shared types and constants for the slot tick scheduler (package slot_sched_pkg).
// Optional jitter feature is selected by the SLOT_JITTER_EN macro in the top file.
package slot_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    DECEL,
    SETTLE
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Level port width for the default SLOW_LOG2 of 23
  localparam int LEVEL_W = 5;

  function automatic int level_width(input int slow_log2);
    return $clog2(slow_log2 + 1);
  endfunction

endpackage

// File: rtl/slot_tick_sched_if.sv
// Control and tick bundle between the game logic and slot_tick_sched.
interface slot_tick_sched_if #(
  parameter int LEVEL_W = slot_sched_pkg::LEVEL_W
);
  logic               spin;
  logic               stop_req;
  logic               pix_tick;
  logic               seg_tick;
  logic               slot_tick;
  logic               busy;
  logic               settled;
  logic [LEVEL_W-1:0] level;

  modport master (
    output spin, stop_req,
    input  pix_tick, seg_tick, slot_tick, busy, settled, level
  );

  modport slave (
    input  spin, stop_req,
    output pix_tick, seg_tick, slot_tick, busy, settled, level
  );
endinterface

// File: rtl/slot_tick_sched_pow2_tick.sv
// Free-running power-of-two clock-enable generator: tick is high when the counter is all ones.
module pow2_tick #(
  parameter int LOG2 = 2
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);
  logic [LOG2-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) cnt <= '0;
    else     cnt <= cnt + LOG2'(1);
  end

  assign tick = &cnt;
endmodule

// File: rtl/slot_tick_sched.sv
// Tick scheduler: pixel/segment enables plus an FSM-sequenced reel-step enable with stepwise deceleration.
// Define SLOT_JITTER_EN to add LFSR-driven extra ticks at the slowest level.
module slot_tick_sched
  import slot_sched_pkg::*;
#(
  parameter int PIX_LOG2  = 2,
  parameter int SEG_LOG2  = 17,
  parameter int FAST_LOG2 = 20,
  parameter int SLOW_LOG2 = 23,
  parameter int STEPS     = 4
) (
  input logic              clk,
  input logic              clr,
  slot_tick_sched_if.slave bus
);
  localparam int LW     = level_width(SLOW_LOG2);
  localparam int STEP_W = $clog2(STEPS + 4);

  state_t                 state;
  logic [SLOW_LOG2-1:0]   pcnt;
  logic [SLOW_LOG2-1:0]   pcnt_max;
  logic [LW-1:0]          level;
  logic [STEP_W-1:0]      step_cnt;
  logic [STEP_W-1:0]      last_step;
  logic                   busy;
  logic                   settled;
  logic                   slot_tick;
  logic                   at_slow;
  logic                   pix_tick;
  logic                   seg_tick;
  logic [1:0]             extra;

  pow2_tick #(.LOG2(PIX_LOG2)) u_pix (.clk(clk), .clr(clr), .tick(pix_tick));
  pow2_tick #(.LOG2(SEG_LOG2)) u_seg (.clk(clk), .clr(clr), .tick(seg_tick));

`ifdef SLOT_JITTER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (clr) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (clr)                                extra <= '0;
    else if (state == SPIN && bus.stop_req) extra <= lfsr[1:0];
  end
`else
  assign extra = '0;
`endif

  assign pcnt_max  = SLOW_LOG2'((64'(1) << level) - 64'(1));
  assign slot_tick = (state == SPIN || state == DECEL) && (pcnt == pcnt_max);
  assign at_slow   = (level == LW'(SLOW_LOG2));

  always_comb begin
    last_step = STEP_W'(STEPS - 1);
    if (at_slow) last_step = last_step + STEP_W'(extra);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      busy     <= 1'b0;
      settled  <= 1'b0;
      level    <= LW'(FAST_LOG2);
      pcnt     <= '0;
      step_cnt <= '0;
    end else begin
      settled <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.spin) begin
            state <= SPIN;
            busy  <= 1'b1;
            level <= LW'(FAST_LOG2);
            pcnt  <= '0;
          end
        end
        SPIN: begin
          pcnt <= slot_tick ? '0 : pcnt + SLOW_LOG2'(1);
          // pcnt keeps running so the first decel tick stays on the spin schedule
          if (bus.stop_req) begin
            state    <= DECEL;
            step_cnt <= '0;
          end
        end
        DECEL: begin
          if (bus.spin) begin
            state <= SPIN;
            level <= LW'(FAST_LOG2);
            pcnt  <= '0;
          end else if (slot_tick) begin
            pcnt <= '0;
            if (step_cnt == last_step) begin
              step_cnt <= '0;
              if (at_slow) begin
                state   <= SETTLE;
                busy    <= 1'b0;
                settled <= 1'b1;
              end else begin
                level <= level + LW'(1);
              end
            end else begin
              step_cnt <= step_cnt + STEP_W'(1);
            end
          end else begin
            pcnt <= pcnt + SLOW_LOG2'(1);
          end
        end
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pix_tick  = pix_tick;
  assign bus.seg_tick  = seg_tick;
  assign bus.slot_tick = slot_tick;
  assign bus.busy      = busy;
  assign bus.settled   = settled;
  assign bus.level     = level;
endmodule

// File: tb/tb_slot_tick_sched.sv
// Randomized bench for slot_tick_sched with a time-based reference model and directed literal checks.
module tb_slot_tick_sched;
  localparam int PIX  = 1;
  localparam int SEG  = 3;
  localparam int FAST = 2;
  localparam int SLOW = 4;
  localparam int STP  = 2;
  localparam int LW   = 3;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  slot_tick_sched_if #(.LEVEL_W(LW)) bus ();

  slot_tick_sched #(
    .PIX_LOG2 (PIX),
    .SEG_LOG2 (SEG),
    .FAST_LOG2(FAST),
    .SLOW_LOG2(SLOW),
    .STEPS    (STP)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 spinning, 2 decelerating, 3 settle pulse.
  // Ticks are tracked as absolute cycle numbers rather than counters.
  int cyc_n = 0;
  int m_k = 0;
  int m_mode = 0;
  int m_level = FAST;
  int m_next = 0;
  int m_left = 0;
  bit model_valid = 1'b0;

  function automatic logic [7:0] expected();
    logic e_pix, e_seg, e_slot, e_busy, e_set;
    e_pix  = (m_k % (2 ** PIX)) == (2 ** PIX) - 1;
    e_seg  = (m_k % (2 ** SEG)) == (2 ** SEG) - 1;
    e_busy = (m_mode == 1 || m_mode == 2);
    e_slot = e_busy && (cyc_n == m_next);
    e_set  = (m_mode == 3);
    return {e_pix, e_seg, e_slot, e_busy, e_set, LW'(m_level)};
  endfunction

  task automatic model_step(input bit s, input bit st, input bit c);
    bit tick;
    tick = (m_mode == 1 || m_mode == 2) && (cyc_n == m_next);
    if (c) begin
      m_mode = 0; m_level = FAST; m_k = 0; model_valid = 1'b1;
    end else begin
      m_k++;
      case (m_mode)
        0: if (s) begin m_mode = 1; m_level = FAST; m_next = cyc_n + 2 ** FAST; end
        1: begin
          if (tick) m_next = cyc_n + 2 ** m_level;
          if (st) begin m_mode = 2; m_left = STP; end
        end
        2: begin
          if (s) begin
            m_mode = 1; m_level = FAST; m_next = cyc_n + 2 ** FAST;
          end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
              if (m_level < SLOW) begin
                m_level++; m_left = STP; m_next = cyc_n + 2 ** m_level;
              end else begin
                m_mode = 3;
              end
            end else begin
              m_next = cyc_n + 2 ** m_level;
            end
          end
        end
        default: m_mode = 0;
      endcase
    end
    cyc_n++;
  endtask

  function automatic logic [7:0] actual();
    return {bus.pix_tick, bus.seg_tick, bus.slot_tick, bus.busy, bus.settled, bus.level};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs for one cycle, advance the model, then compare on the falling edge.
  task automatic step(input bit s, input bit st, input bit c);
    logic [7:0] e;
    bus.spin = s; bus.stop_req = st; clr = c;
    @(posedge clk);
    #1;
    model_step(s, st, c);
    @(negedge clk);
    if (model_valid) begin
      e = expected();
      checks++;
      if (actual() !== e) begin
        failures++;
        $display("FAIL outputs cycle %0d: got %b expected %b (pix seg slot busy settled level)",
                 cyc_n, actual(), e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, g, n, sc, sgap, lsum, first, last, cnt, bad;
    bus.spin = 1'b0;
    bus.stop_req = 1'b0;
    @(negedge clk);

    step(0, 0, 1);
    step(0, 0, 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_level", int'(bus.level), 2);
    chk("reset_ticks", int'({bus.pix_tick, bus.seg_tick, bus.slot_tick, bus.settled}), 0);

    // Idle after reset: free-running ticks only
    n = 0; sc = 0; cnt = 0; first = -1;
    for (int i = 0; i < 100; i++) begin
      n += int'(bus.pix_tick);
      if (bus.seg_tick) begin cnt++; if (first < 0) first = i; end
      sc += int'(bus.slot_tick) + int'(bus.busy) + int'(bus.settled);
      step(0, 0, 0);
    end
    chk("idle_pix_count", n, 50);
    chk("idle_seg_count", cnt, 12);
    chk("first_seg_index", first, 7);
    chk("idle_slot_busy_settled", sc, 0);

    // Spin: busy next cycle, first tick 4 cycles after the request
    step(1, 0, 0);
    chk("spin_busy", int'(bus.busy), 1);
    chk("spin_level", int'(bus.level), 2);
    t = 0;
    while (!bus.slot_tick && t < 50) begin step(0, 0, 0); t++; end
    chk("first_slot_latency", t + 1, 4);
    step(0, 0, 0);
    g = 1;
    while (!bus.slot_tick && g < 50) begin step(0, 0, 0); g++; end
    chk("spin_period", g, 4);

    // Stop right after a tick: 2@4, 2@8, 2@16 then a settled pulse
    step(0, 0, 0);
    step(0, 1, 0);
    n = 0; sc = 0; sgap = -1; lsum = 0; first = -1; last = -1;
    for (int i = 0; i < 100; i++) begin
      if (bus.slot_tick) begin
        n++; lsum += int'(bus.level);
        if (first < 0) first = i;
        last = i;
      end
      if (bus.settled) begin sc++; sgap = i - last; end
      step(0, 0, 0);
    end
    chk("decel_ticks", n, 6);
    chk("decel_level_sum", lsum, 18);
    chk("decel_first_tick", first, 2);
    chk("decel_span", last - first, 52);
    chk("settled_count", sc, 1);
    chk("settled_after_tick", sgap, 1);
    chk("idle_after_settle", int'(bus.busy), 0);

    // Respin while decelerating at level 3
    step(1, 0, 0);
    step(0, 1, 0);
    t = 0;
    while (bus.level != 3'd3 && t < 100) begin step(0, 0, 0); t++; end
    chk("reached_level3", int'(bus.level), 3);
    step(1, 0, 0);
    chk("respin_level", int'(bus.level), 2);
    t = 0;
    while (!bus.slot_tick && t < 50) begin step(0, 0, 0); t++; end
    chk("respin_latency", t + 1, 4);
    sc = 0;
    for (int i = 0; i < 60; i++) begin sc += int'(bus.settled); step(0, 0, 0); end
    chk("respin_no_settle", sc, 0);

    // Reset mid-decel aborts silently
    step(0, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    step(0, 0, 1);
    chk("abort_outputs", int'(actual()), 2);
    sc = 0;
    for (int i = 0; i < 40; i++) begin
      sc += int'(bus.busy) + int'(bus.settled) + int'(bus.slot_tick);
      step(0, 0, 0);
    end
    chk("abort_quiet", sc, 0);
    step(1, 0, 0);
    chk("abort_respin_busy", int'(bus.busy), 1);

    // spin and stop_req together in idle: spin only
    step(0, 0, 1);
    step(1, 1, 0);
    chk("both_busy", int'(bus.busy), 1);
    n = 0; bad = 0;
    for (int i = 0; i < 30; i++) begin
      n += int'(bus.slot_tick);
      if (bus.level != 3'd2) bad++;
      step(0, 0, 0);
    end
    chk("both_spin_ticks", n, 7);
    chk("both_no_decel", bad, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 999) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
